// File: rtl/disp_arbiter_pkg.sv
// Shared types and constants for the score-display arbiter.
package disp_pkg;
  localparam int VAL_W = 32;
  localparam logic [3:0] SRC_SCORE = 4'd0;
  localparam logic [VAL_W-1:0] DEFAULT_SAT_MAX = 32'd99_999_999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic logic [VAL_W-1:0] sat(input logic [VAL_W-1:0] v,
                                           input logic [VAL_W-1:0] max);
    return (v > max) ? max : v;
  endfunction
endpackage

// File: rtl/disp_arbiter_if.sv
// Bus between the game logic / event sources (master) and the display arbiter (slave).
interface disp_arbiter_if #(
  parameter int N_EV = 3
);
  logic [disp_pkg::VAL_W-1:0]      SCORE;
  logic [N_EV-1:0]                 EV_REQ;
  logic [disp_pkg::VAL_W*N_EV-1:0] EV_VALUE;
  logic [N_EV-1:0]                 EV_ACK;
  logic [N_EV-1:0]                 EV_DONE;
  logic [disp_pkg::VAL_W-1:0]      DISP_VALUE;
  logic                            DISP_BLANK;
  logic [3:0]                      DISP_SRC;
  logic                            BUSY;

  // Handshake: EV_REQ[i] is a level held with EV_VALUE slice i stable until the
  // one-cycle EV_ACK[i]; ACK means the value is latched and the source may drop or
  // re-raise REQ. Dropping REQ before ACK withdraws it. EV_DONE[i] marks end of hold.
  modport master (
    output SCORE, EV_REQ, EV_VALUE,
    input  EV_ACK, EV_DONE, DISP_VALUE, DISP_BLANK, DISP_SRC, BUSY
  );
  modport slave (
    input  SCORE, EV_REQ, EV_VALUE,
    output EV_ACK, EV_DONE, DISP_VALUE, DISP_BLANK, DISP_SRC, BUSY
  );
endinterface

// File: rtl/disp_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  localparam logic [IW:0] N_L = (IW+1)'(N);

  logic [IW:0]   s;
  logic [IW-1:0] c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    s     = '0;
    c     = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= N_L) s = s - N_L;
      c = s[IW-1:0];
      if (!any && req[c]) begin
        grant[c] = 1'b1;
        idx      = c;
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/disp_arbiter.sv
// Shares the score display between the live score and round-robin event sources,
// holding each accepted event for a fixed time with optional blinking.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int              N_EV         = 3,
  parameter int              HOLD_CYCLES  = 50_000_000,
  parameter int              BLINK_CYCLES = 12_500_000,
  parameter int              GAP_CYCLES   = 1_000_000,
  parameter logic [N_EV-1:0] BLINK_MASK   = 3'b010,
  parameter logic [31:0]     SAT_MAX      = DEFAULT_SAT_MAX
) (
  input  logic              CLK,
  input  logic              RST,
  disp_arbiter_if.slave     bus,
  output state_e            DBG_STATE
);
  localparam int IW = (N_EV > 1) ? $clog2(N_EV) : 1;
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] PTR_LAST  = IW'(N_EV - 1);

  state_e          state;
  logic [HW-1:0]   hold_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   cur_g;
  logic [N_EV-1:0] ev_ack, ev_done;
  logic [VAL_W-1:0] disp_value;
  logic            disp_blank;
  logic [3:0]      disp_src;
  logic            busy;

  logic [N_EV-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_any;
  logic [VAL_W-1:0] grant_val;
  logic [N_EV-1:0]  cur_onehot;
  logic [31:0]      next_hold;
  logic             next_blank_off;

  rr_arbiter #(.N(N_EV), .IW(IW)) u_rr (
    .req   (bus.EV_REQ),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    grant_val  = '0;
    cur_onehot = '0;
    for (int i = 0; i < N_EV; i++) begin
      if (grant[i]) grant_val = bus.EV_VALUE[VAL_W*i +: VAL_W];
      if (cur_g == IW'(i)) cur_onehot[i] = 1'b1;
    end
    // Blink phase comes straight from the hold count the next cycle will show.
    next_hold      = 32'(hold_cnt) + 32'd1;
    next_blank_off = (next_hold % 32'(BLINK_CYCLES)) >= 32'(BLINK_CYCLES / 2);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      rr_ptr     <= '0;
      cur_g      <= '0;
      ev_ack     <= '0;
      ev_done    <= '0;
      disp_value <= '0;
      disp_blank <= 1'b0;
      disp_src   <= SRC_SCORE;
      busy       <= 1'b0;
    end else begin
      ev_ack  <= '0;
      ev_done <= '0;
      case (state)
        IDLE: begin
          disp_blank <= 1'b0;
          if (grant_any) begin
            state      <= SHOW;
            ev_ack     <= grant;
            disp_value <= sat(grant_val, SAT_MAX);
            disp_src   <= 4'(grant_idx) + 4'd1;
            hold_cnt   <= '0;
            cur_g      <= grant_idx;
            rr_ptr     <= (grant_idx == PTR_LAST) ? '0 : grant_idx + IW'(1);
            busy       <= 1'b1;
          end else begin
            disp_value <= sat(bus.SCORE, SAT_MAX);
            disp_src   <= SRC_SCORE;
            busy       <= 1'b0;
          end
        end
        SHOW: begin
          if (hold_cnt == HOLD_LAST) begin
            ev_done    <= cur_onehot;
            disp_blank <= 1'b0;
            disp_src   <= SRC_SCORE;
            disp_value <= sat(bus.SCORE, SAT_MAX);
            gap_cnt    <= '0;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            hold_cnt   <= hold_cnt + HW'(1);
            disp_blank <= BLINK_MASK[cur_g] && next_blank_off;
          end
        end
        GAP: begin
          disp_value <= sat(bus.SCORE, SAT_MAX);
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.EV_ACK     = ev_ack;
  assign bus.EV_DONE    = ev_done;
  assign bus.DISP_VALUE = disp_value;
  assign bus.DISP_BLANK = disp_blank;
  assign bus.DISP_SRC   = disp_src;
  assign bus.BUSY       = busy;
  assign DBG_STATE      = state;
endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
Shares the single 8-digit score display among the live game score and N_EV event sources (high-score flash, countdown, bonus). Event sources request the display with a REQ/ACK handshake. The block grants them round-robin, holds each granted value for a fixed time with optional blinking, then returns to the live score. Its outputs feed the seg controller's BINARY_SCORE input, plus a blank signal for a digit-enable gate.

Parameters:
N_EV, 3, number of event requesters (1..8)
HOLD_CYCLES, 50_000_000, cycles an accepted event value stays on the display
BLINK_CYCLES, 12_500_000, blink period in cycles; must be even and >= 2
GAP_CYCLES, 1_000_000, minimum cycles of live score between two events; 0 is allowed
BLINK_MASK, 3'b010, bit i = 1 means event i blinks while shown
SAT_MAX, 99_999_999, saturation ceiling for the displayed value

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
SCORE  in  32  live score, unsigned binary
EV_REQ  in  N_EV  level request per source; held high until ACK
EV_VALUE  in  32*N_EV  flattened values; slice i is [32*i+31:32*i], stable while EV_REQ[i]
EV_ACK  out  N_EV  one-cycle pulse: request i accepted and value latched
EV_DONE  out  N_EV  one-cycle pulse: hold time of event i expired
DISP_VALUE  out  32  value to display, saturated to SAT_MAX
DISP_BLANK  out  1  1 means all digits dark (blink off-phase)
DISP_SRC  out  4  current source: 0 = live score, i+1 = event i
BUSY  out  1  1 in SHOW or GAP

Behaviour:
- All outputs are registered.
- Reset values: DISP_VALUE=0, DISP_BLANK=0, DISP_SRC=0, EV_ACK=0, EV_DONE=0, BUSY=0, state=IDLE, rr_ptr=0, all counters 0.
- Reset asserted mid-SHOW or mid-GAP: immediate return to reset values. No EV_DONE is issued for the aborted event.
- Saturation: DISP_VALUE = (v > SAT_MAX) ? SAT_MAX : v, unsigned compare.
- IDLE:
  - DISP_VALUE follows saturated SCORE with 1-cycle latency. DISP_SRC=0, DISP_BLANK=0.
  - If any EV_REQ is high at edge t, grant the first set bit searching upward from rr_ptr, wrapping around.
  - At edge t+1: EV_ACK[g]=1 for exactly that cycle, DISP_VALUE=sat(EV_VALUE[g]), DISP_SRC=g+1, state=SHOW, hold counter=0, rr_ptr=(g+1) mod N_EV.
- SHOW:
  - DISP_VALUE is frozen at the latched value; later EV_VALUE or EV_REQ changes are ignored.
  - The hold counter increments each cycle. State stays SHOW for exactly HOLD_CYCLES cycles (cycles t+1..t+HOLD_CYCLES).
  - If BLINK_MASK[g]=1: DISP_BLANK=1 when (hold counter mod BLINK_CYCLES) >= BLINK_CYCLES/2, else 0. The first half-period is lit.
  - If BLINK_MASK[g]=0: DISP_BLANK stays 0.
  - At the edge ending the last SHOW cycle: EV_DONE[g]=1 for one cycle, DISP_BLANK=0, DISP_SRC=0, DISP_VALUE=sat(SCORE). Next state is GAP, or IDLE if GAP_CYCLES=0.
- GAP: shows live score as in IDLE for GAP_CYCLES cycles, then IDLE. Requests are not sampled in GAP; they stay pending because REQ is a level.
- Handshake rules:
  - A requester must keep EV_REQ high until it sees its ACK.
  - Dropping EV_REQ before ACK withdraws the request with no side effects.
  - A requester may re-raise EV_REQ in the cycle after ACK; the new request is served only after SHOW and GAP complete.
  - EV_DONE and a new EV_REQ in the same cycle: the request is not sampled until IDLE.
- Counter widths: $clog2(HOLD_CYCLES+1) and $clog2(GAP_CYCLES+1). The blink phase is derived from the hold counter; no separate free-running counter.
- Fairness: with all sources requesting continuously, grants rotate 0,1,2,0,... No source waits more than N_EV-1 events.

Decomposition:
- Shared package disp_pkg holds:
  - state enum {IDLE, SHOW, GAP}
  - SRC_SCORE=0
  - DEFAULT_SAT_MAX=99_999_999
  - the value slice-width constant 32
- Sub-module rr_arbiter (request vector and pointer in, one-hot grant and index out, purely combinational) is natural and reusable by the input-event handler.

Test Plan:
- Reset, then SCORE=1234 -> DISP_VALUE=1234 one cycle later, DISP_SRC=0, BUSY=0.
- SCORE=123_456_789 -> DISP_VALUE=99_999_999.
- HOLD=8, BLINK=4, GAP=2, N_EV=3; EV_REQ[1] with value 777 at edge t:
  - ACK[1] at t+1.
  - DISP_VALUE=777 for t+1..t+8; DISP_BLANK pattern 0,0,1,1,0,0,1,1.
  - DONE[1] at t+9, score shown from t+9, IDLE at t+11.
- EV_REQ=3'b111 held continuously, each requester dropping REQ on its ACK and re-raising next cycle -> ACK order 0,1,2,0,1,2. Each pair of ACKs is separated by HOLD+GAP+1 cycles.
- EV_REQ[2] raised for 1 cycle during GAP and dropped -> never ACKed, no state change.
- RST asserted at hold count 3 of event 0 -> outputs return to reset values on the same edge, no DONE[0]. A request after reset is granted from rr_ptr=0.
